// File: rtl/neural_engine_pkg.sv
// Shared types and defaults for the neural engine result path.
package neural_engine_pkg;
  localparam int RESULT_W          = 16;
  localparam int RESULT_FIFO_DEPTH = 16;

  typedef logic [RESULT_W-1:0] result_word_t;
endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; RESET_VAL=1 suppresses a level already high at reset release.
module rise_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic level_in,
  output logic rise_out
);

  logic level_q;
  logic level_d;

  assign level_d = level_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_q <= RESET_VAL;
    else       level_q <= level_d;
  end

  assign rise_out = level_in & ~level_q;

endmodule

// File: rtl/result_collector.sv
// Captures result words on rising edges of in_ready into a FWFT FIFO drained by valid/ready,
// with occupancy, saturating accepted-push total and sticky overflow.
module result_collector
  import neural_engine_pkg::*;
#(
  parameter int DATA_W  = RESULT_W,
  parameter int DEPTH   = RESULT_FIFO_DEPTH,
  parameter int TOTAL_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [TOTAL_W-1:0]         total
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic               overflow_q, overflow_d;
  logic               push_req, push_ok, pop, mem_we;

  rise_detect #(.RESET_VAL(1'b1)) u_rdy_edge (
    .clk      (clk),
    .reset    (reset),
    .level_in (in_ready),
    .rise_out (push_req)
  );

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign total     = total_q;
  assign overflow  = overflow_q;

  // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
  assign push_ok = push_req & (~full | pop);

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    total_d    = total_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    if (clear) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      total_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (total_q != {TOTAL_W{1'b1}}) total_d = total_q + TOTAL_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push_ok) count_d = count_q - CNT_W'(1);
      if (push_req && !push_ok) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      total_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      total_q    <= total_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is reset so an empty-FIFO out_data reads 0 rather than X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule
